// File: rtl/axilite_bk_pkg.sv
// axilite_bk_pkg: shared types and constants for the two-requester AXI-lite backend arbiter
package axilite_bk_pkg;
    localparam int ADDR_W = 15;
    localparam int DATA_W = 32;
    localparam logic [DATA_W-1:0] TMO_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {IDLE, ISSUE_W, ISSUE_R, WAIT_R} state_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [3:0]        strb;
    } slot_t;
endpackage

// File: rtl/axilite_bk_slot.sv
// axilite_bk_slot: single-entry command holder with capture, overflow detect and free
module axilite_bk_slot
    import axilite_bk_pkg::*;
(
    input  logic              axi_aclk,
    input  logic              axi_aresetn,
    input  logic              start,
    input  logic              free,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    input  logic [3:0]        strb,
    output slot_t             slot,
    output logic              ovf
);
    // A slot being freed this cycle can take the new command without overflowing
    assign ovf = start && slot.valid && !free;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) slot <= '0;
        else if (start && !ovf) slot <= '{valid: 1'b1, addr: addr, data: data, strb: strb};
        else if (free) slot.valid <= 1'b0;
    end
endmodule

// File: rtl/axilite_bk_arbiter.sv
// axilite_bk_arbiter: round-robin arbiter of two requesters onto one backend, one transaction at a time
module axilite_bk_arbiter
    import axilite_bk_pkg::*;
#(
    parameter int unsigned TMO_CYCLES = 255
) (
    input  logic                   axi_aclk,
    input  logic                   axi_aresetn,
    input  logic [1:0]             up_wstart,
    input  logic [1:0][ADDR_W-1:0] up_waddr,
    input  logic [1:0][DATA_W-1:0] up_wdata,
    input  logic [1:0][3:0]        up_wstrb,
    input  logic [1:0]             up_rstart,
    input  logic [1:0][ADDR_W-1:0] up_raddr,
    output logic [1:0]             up_rdone,
    output logic [1:0][DATA_W-1:0] up_rdata,
    output logic                   dn_wstart,
    output logic [ADDR_W-1:0]      dn_waddr,
    output logic [DATA_W-1:0]      dn_wdata,
    output logic [3:0]             dn_wstrb,
    output logic                   dn_rstart,
    output logic [ADDR_W-1:0]      dn_raddr,
    input  logic                   dn_rdone,
    input  logic [DATA_W-1:0]      dn_rdata,
    input  logic                   arb_enable,
    output logic [1:0]             err_ovf,
    output logic                   err_tmo,
    input  logic                   err_clr
);
    localparam logic [15:0] TMO_LAST = 16'(TMO_CYCLES - 1);

    state_t state_q, state_d;
    logic gnt_q, gnt_d, sel, tmo_evt, unused_rd;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0] wovf, rovf, wfree, rfree, pend, rdone_d;
    logic [1:0][DATA_W-1:0] rdata_d;
    slot_t wslot [2];
    slot_t rslot [2];

    for (genvar i = 0; i < 2; i++) begin : g_req
        axilite_bk_slot u_wslot (
            .axi_aclk, .axi_aresetn, .start(up_wstart[i]), .free(wfree[i]),
            .addr(up_waddr[i]), .data(up_wdata[i]), .strb(up_wstrb[i]),
            .slot(wslot[i]), .ovf(wovf[i])
        );
        axilite_bk_slot u_rslot (
            .axi_aclk, .axi_aresetn, .start(up_rstart[i]), .free(rfree[i]),
            .addr(up_raddr[i]), .data('0), .strb('0),
            .slot(rslot[i]), .ovf(rovf[i])
        );
        assign wfree[i] = state_q == ISSUE_W && gnt_q == 1'(i);
        assign rfree[i] = state_q == ISSUE_R && gnt_q == 1'(i);
        assign pend[i]  = wslot[i].valid || rslot[i].valid;
    end

    assign unused_rd = ^{rslot[0].data, rslot[0].strb, rslot[1].data, rslot[1].strb};

    // gnt_q doubles as the round-robin pointer: under contention the other requester wins
    assign sel = &pend ? ~gnt_q : pend[1];

    assign dn_wstart = state_q == ISSUE_W;
    assign dn_waddr  = dn_wstart ? wslot[gnt_q].addr : '0;
    assign dn_wdata  = dn_wstart ? wslot[gnt_q].data : '0;
    assign dn_wstrb  = dn_wstart ? wslot[gnt_q].strb : '0;
    assign dn_rstart = state_q == ISSUE_R;
    assign dn_raddr  = dn_rstart ? rslot[gnt_q].addr : '0;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        cnt_d   = '0;
        rdone_d = '0;
        rdata_d = '0;
        tmo_evt = 1'b0;
        case (state_q)
            IDLE: if (arb_enable && |pend) begin
                gnt_d   = sel;
                state_d = wslot[sel].valid ? ISSUE_W : ISSUE_R;
            end
            ISSUE_W: state_d = IDLE;
            ISSUE_R: state_d = WAIT_R;
            WAIT_R: if (dn_rdone || cnt_q == TMO_LAST) begin
                state_d        = IDLE;
                rdone_d[gnt_q] = 1'b1;
                rdata_d[gnt_q] = dn_rdone ? dn_rdata : TMO_DATA;
                tmo_evt        = !dn_rdone;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q  <= IDLE;
            gnt_q    <= 1'b1;
            cnt_q    <= '0;
            up_rdone <= '0;
            up_rdata <= '0;
            err_ovf  <= '0;
            err_tmo  <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            cnt_q    <= cnt_d;
            up_rdone <= rdone_d;
            up_rdata <= rdata_d;
            err_ovf  <= (err_clr ? 2'b00 : err_ovf) | wovf | rovf;
            err_tmo  <= (err_clr ? 1'b0 : err_tmo) | tmo_evt;
        end
    end
endmodule

// File: tb/tb_axilite_bk_arbiter.sv
// tb_axilite_bk_arbiter: directed self-checking bench for the two-requester backend arbiter
module tb_axilite_bk_arbiter;
    logic axi_aclk = 1'b0;
    logic axi_aresetn = 1'b0;
    logic [1:0] up_wstart = '0, up_rstart = '0, up_rdone, err_ovf;
    logic [1:0][14:0] up_waddr = '0, up_raddr = '0;
    logic [1:0][31:0] up_wdata = '0, up_rdata;
    logic [1:0][3:0] up_wstrb = '0;
    logic dn_wstart, dn_rstart, err_tmo;
    logic dn_rdone = 1'b0, arb_enable = 1'b0, err_clr = 1'b0;
    logic [14:0] dn_waddr, dn_raddr;
    logic [31:0] dn_wdata, dn_rdata = '0;
    logic [3:0] dn_wstrb;
    int vectors = 0, miscompares = 0;

    axilite_bk_arbiter #(.TMO_CYCLES(8)) dut (
        .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
        .up_wstart(up_wstart), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wstrb(up_wstrb),
        .up_rstart(up_rstart), .up_raddr(up_raddr), .up_rdone(up_rdone), .up_rdata(up_rdata),
        .dn_wstart(dn_wstart), .dn_waddr(dn_waddr), .dn_wdata(dn_wdata), .dn_wstrb(dn_wstrb),
        .dn_rstart(dn_rstart), .dn_raddr(dn_raddr), .dn_rdone(dn_rdone), .dn_rdata(dn_rdata),
        .arb_enable(arb_enable), .err_ovf(err_ovf), .err_tmo(err_tmo), .err_clr(err_clr)
    );

    always #5 axi_aclk = ~axi_aclk;

    task automatic step();
        @(negedge axi_aclk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_out(input string tag);
        chk({tag, "_wst"}, dn_wstart, 0);
        chk({tag, "_rst"}, dn_rstart, 0);
        chk({tag, "_waddr"}, dn_waddr, 0);
        chk({tag, "_wdata"}, dn_wdata, 0);
        chk({tag, "_raddr"}, dn_raddr, 0);
        chk({tag, "_rdone"}, up_rdone, 0);
        chk({tag, "_rdata"}, up_rdata, 0);
        chk({tag, "_ovf"}, err_ovf, 0);
        chk({tag, "_tmo"}, err_tmo, 0);
    endtask

    initial begin
        step(); step();
        chk_idle_out("reset");
        axi_aresetn = 1'b1; arb_enable = 1'b1;

        // both requesters read together: requester 0 first, then 1
        step(); up_rstart = 2'b11; up_raddr[0] = 15'h100; up_raddr[1] = 15'h200;
        step(); up_rstart = '0; chk("rr_n1_rst", dn_rstart, 0);
        step(); chk("rr_r0_rst", dn_rstart, 1); chk("rr_r0_raddr", dn_raddr, 15'h100); chk("rr_r0_wst", dn_wstart, 0);
        step(); chk("rr_r0_pulse", dn_rstart, 0);
        step();
        step(); dn_rdone = 1'b1; dn_rdata = 32'hAAAA_0001;
        step(); dn_rdone = 1'b0;
        chk("rr_r0_done", up_rdone, 2'b01); chk("rr_r0_data", up_rdata[0], 32'hAAAA_0001); chk("rr_r0_other", up_rdata[1], 0);
        step(); chk("rr_r1_rst", dn_rstart, 1); chk("rr_r1_raddr", dn_raddr, 15'h200); chk("rr_r1_nodone", up_rdone, 0);
        step(); step();
        step(); dn_rdone = 1'b1; dn_rdata = 32'hBBBB_0002;
        step(); dn_rdone = 1'b0;
        chk("rr_r1_done", up_rdone, 2'b10); chk("rr_r1_data", up_rdata[1], 32'hBBBB_0002);

        // posted write latency: pulse in cycle 0 -> dn_wstart in cycle 2
        step(); up_wstart = 2'b01; up_waddr[0] = 15'h0010; up_wdata[0] = 32'h1234_5678; up_wstrb[0] = 4'hF;
        step(); up_wstart = '0; up_wdata[0] = '0; chk("wr_c1_wst", dn_wstart, 0);
        step();
        chk("wr_c2_wst", dn_wstart, 1); chk("wr_c2_waddr", dn_waddr, 15'h0010);
        chk("wr_c2_wdata", dn_wdata, 32'h1234_5678); chk("wr_c2_wstrb", dn_wstrb, 4'hF); chk("wr_c2_rst", dn_rstart, 0);
        step(); chk("wr_c3_wst", dn_wstart, 0); chk("wr_c3_waddr", dn_waddr, 0); chk("wr_c3_wdata", dn_wdata, 0);

        // requester 1 write and read together: write first, no overlap
        step(); up_wstart = 2'b10; up_rstart = 2'b10; up_waddr[1] = 15'h22; up_wdata[1] = 32'hCAFE_0000; up_wstrb[1] = 4'h3; up_raddr[1] = 15'h33;
        step(); up_wstart = '0; up_rstart = '0;
        step(); chk("wr_rd_wst", dn_wstart, 1); chk("wr_rd_rst0", dn_rstart, 0);
        chk("wr_rd_waddr", dn_waddr, 15'h22); chk("wr_rd_wdata", dn_wdata, 32'hCAFE_0000); chk("wr_rd_wstrb", dn_wstrb, 4'h3);
        step(); chk("wr_rd_gap_w", dn_wstart, 0); chk("wr_rd_gap_r", dn_rstart, 0);
        step(); chk("wr_rd_rst", dn_rstart, 1); chk("wr_rd_wst0", dn_wstart, 0); chk("wr_rd_raddr", dn_raddr, 15'h33);
        step(); dn_rdone = 1'b1; dn_rdata = 32'h5555_1111;
        step(); dn_rdone = 1'b0; chk("wr_rd_done", up_rdone, 2'b10); chk("wr_rd_data", up_rdata[1], 32'h5555_1111);

        // overflow while arbitration disabled, then freed-same-cycle capture
        step(); arb_enable = 1'b0; up_wstart = 2'b01; up_waddr[0] = 15'h44; up_wdata[0] = 32'h11; up_wstrb[0] = 4'h1;
        step(); up_waddr[0] = 15'h55; up_wdata[0] = 32'h22;
        step(); up_wstart = '0; arb_enable = 1'b1; chk("ovf_flag", err_ovf, 2'b01); chk("ovf_hold", dn_wstart, 0);
        step(); chk("ovf_wst", dn_wstart, 1); chk("ovf_waddr", dn_waddr, 15'h44); chk("ovf_wdata", dn_wdata, 32'h11); chk("ovf_wstrb", dn_wstrb, 4'h1);
        up_wstart = 2'b01; up_waddr[0] = 15'h66; up_wdata[0] = 32'h33; up_wstrb[0] = 4'h2; err_clr = 1'b1;
        step(); up_wstart = '0; err_clr = 1'b0; chk("free_same_ovf", err_ovf, 2'b00);
        step(); chk("free_same_wst", dn_wstart, 1); chk("free_same_waddr", dn_waddr, 15'h66); chk("free_same_wdata", dn_wdata, 32'h33);

        // read timeout after 8 WAIT_R cycles
        step(); up_rstart = 2'b01; up_raddr[0] = 15'h77;
        step(); up_rstart = '0;
        step(); chk("tmo_rst", dn_rstart, 1); chk("tmo_raddr", dn_raddr, 15'h77);
        for (int k = 3; k <= 10; k++) begin
            step(); chk("tmo_wait", up_rdone, 0);
        end
        step(); chk("tmo_done", up_rdone, 2'b01); chk("tmo_data", up_rdata[0], 32'hDEAD_BEEF); chk("tmo_flag", err_tmo, 1);
        step(); dn_rdone = 1'b1; dn_rdata = 32'h0000_0999;
        step(); dn_rdone = 1'b0; chk("tmo_late", up_rdone, 0); chk("tmo_sticky", err_tmo, 1); err_clr = 1'b1;
        step(); err_clr = 1'b0; chk("tmo_clr", err_tmo, 0);

        // completion in the expiry cycle beats the timeout
        up_rstart = 2'b01; up_raddr[0] = 15'h78;
        step(); up_rstart = '0;
        step(); chk("prec_rst", dn_rstart, 1);
        for (int k = 3; k <= 9; k++) step();
        step(); dn_rdone = 1'b1; dn_rdata = 32'h0BAD_0001;
        step(); dn_rdone = 1'b0;
        chk("prec_done", up_rdone, 2'b01); chk("prec_data", up_rdata[0], 32'h0BAD_0001); chk("prec_tmo", err_tmo, 0);

        // reset during WAIT_R
        step(); up_rstart = 2'b10; up_raddr[1] = 15'h12;
        step(); up_rstart = '0;
        step(); chk("rst_rst", dn_rstart, 1);
        step(); step(); axi_aresetn = 1'b0; #1;
        chk_idle_out("rst_mid");
        step(); step(); axi_aresetn = 1'b1; dn_rdone = 1'b1; dn_rdata = 32'h5A5A_5A5A;
        step(); dn_rdone = 1'b0; chk("rst_no_done1", up_rdone, 0);
        step(); chk("rst_no_done2", up_rdone, 0); chk("rst_no_rst", dn_rstart, 0);
        up_rstart = 2'b01; up_raddr[0] = 15'h34;
        step(); up_rstart = '0;
        step(); chk("rst_next_rst", dn_rstart, 1); chk("rst_next_raddr", dn_raddr, 15'h34);
        step(); dn_rdone = 1'b1; dn_rdata = 32'h7777_7777;
        step(); dn_rdone = 1'b0; chk("rst_next_done", up_rdone, 2'b01); chk("rst_next_data", up_rdata[0], 32'h7777_7777);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/axilite_bk_arbiter.md
AXILITE_BK_ARBITER -- requirements
Module: axilite_bk_arbiter

Interface
REQ-001 SHALL have parameter TMO_CYCLES, default 255, giving the read-timeout in clocks (1..65535).
REQ-002 SHALL have port axi_aclk, input, 1, the single clock for all logic.
REQ-003 SHALL have port axi_aresetn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port up_wstart, input, 2, the per-requester write-start pulse; bit i is requester i.
REQ-005 SHALL have port up_waddr, input, 2x15 packed, the write address; slice i belongs to requester i.
REQ-006 SHALL have port up_wdata, input, 2x32 packed, the write data.
REQ-007 SHALL have port up_wstrb, input, 2x4 packed, the write byte strobes.
REQ-008 SHALL have port up_rstart, input, 2, the per-requester read-start pulse.
REQ-009 SHALL have port up_raddr, input, 2x15 packed, the read address.
REQ-010 SHALL have port up_rdone, output, 2, a one-cycle read-complete pulse per requester.
REQ-011 SHALL have port up_rdata, output, 2x32 packed, the read data, valid only while the matching up_rdone bit is high.
REQ-012 SHALL have ports dn_wstart/dn_waddr/dn_wdata/dn_wstrb, outputs, 1/15/32/4, the shared backend write command.
REQ-013 SHALL have ports dn_rstart/dn_raddr, outputs, 1/15, the shared backend read command.
REQ-014 SHALL have ports dn_rdone/dn_rdata, inputs, 1/32, the backend read completion.
REQ-015 SHALL have port arb_enable, input, 1; while low, no new grants are made.
REQ-016 SHALL have ports err_ovf (output, 2) and err_tmo (output, 1), sticky error flags.
REQ-017 SHALL have port err_clr, input, 1; a single-cycle pulse clears all error flags.

Function
REQ-018 Slots: SHALL hold one write slot and one read slot per requester, 4 slots total.
REQ-019 Capture: a start pulse SHALL load its slot at the same clock edge; the slot is valid from the next cycle.
REQ-020 Overflow: a start pulse to an already-valid slot SHALL be dropped and set err_ovf[i].
REQ-021 Slot freed in the same cycle as a new pulse arrives: the pulse SHALL be accepted, with no overflow.
REQ-022 FSM states SHALL be IDLE, ISSUE_W, ISSUE_R and WAIT_R.
REQ-023 IDLE: with arb_enable=1 and any slot valid, the FSM SHALL grant one requester and go to ISSUE_W if that requester's write slot is valid, else ISSUE_R.
REQ-024 Round-robin: if both requesters have pending work, the one not granted last SHALL win; the pointer updates on each grant.
REQ-025 Write-before-read: a write SHALL take priority over a read within the same requester.
REQ-026 ISSUE_W: dn_wstart SHALL be high for exactly one cycle with the slot contents, the slot is freed, and the FSM returns to IDLE (posted write).
REQ-027 Write latency: a pulse at cycle 0 into an idle arbiter SHALL produce dn_wstart in cycle 2.
REQ-028 ISSUE_R: dn_rstart SHALL be high for exactly one cycle, the slot is freed, and the FSM goes to WAIT_R.
REQ-029 WAIT_R, completion: when dn_rdone=1, the arbiter SHALL pulse the granted up_rdone bit the next cycle with the registered dn_rdata, then return to IDLE.
REQ-030 WAIT_R, timeout: a 16-bit counter SHALL count WAIT_R cycles.
REQ-031 On reaching TMO_CYCLES without dn_rdone, the arbiter SHALL return 32'hDEAD_BEEF with up_rdone, set err_tmo, and go to IDLE.
REQ-032 dn_rdone outside WAIT_R SHALL be ignored, including a late completion after a timeout.
REQ-033 dn_rdone in the same cycle the counter expires SHALL take precedence over the timeout.
REQ-034 arb_enable falling mid-transaction SHALL NOT affect in-flight work; slots keep capturing.
REQ-035 Only one backend transaction SHALL be outstanding at a time; dn_wstart and dn_rstart are never high together.
REQ-036 err_clr together with a new error event in the same cycle: the flag SHALL remain set.
REQ-037 dn_* address, data and strobe outputs SHALL be zero whenever their start signal is low.

Reset
REQ-038 On reset, all outputs SHALL be 0, all slots empty, the state IDLE and the timeout counter 0.
REQ-039 On reset, the round-robin pointer SHALL be set so that requester 0 wins the first contention.
REQ-040 Reset asserted mid-transaction SHALL discard in-flight and pending work, with no up_rdone after release.

Structure
REQ-041 Package axilite_bk_pkg SHALL hold the state enum, the slot struct (valid/addr/data/strb), ADDR_W=15, DATA_W=32 and TMO_DATA=32'hDEAD_BEEF.
REQ-042 Sub-module axilite_bk_slot SHALL implement one capture/overflow/free slot and be instantiated 4 times.

Verification
REQ-043 Requester 0 write 0x0010/0x1234_5678/0xF at cycle 0 -> dn_wstart in cycle 2 with the same values, one cycle wide.
REQ-044 Both requesters read in the same cycle, dn_rdone after 3 cycles each -> requester 0 is served first, then requester 1; each up_rdata matches its dn_rdata.
REQ-045 Requester 1 issues a write and a read together -> the write is issued before the read; no overlap on dn_*.
REQ-046 Second up_wstart to requester 0 while its slot is pending and arb_enable=0 -> err_ovf=2'b01; the first write is still issued after enable.
REQ-047 TMO_CYCLES=8 with no dn_rdone -> up_rdone carries 0xDEAD_BEEF; err_tmo=1; a later dn_rdone is ignored; err_clr clears err_tmo.
REQ-048 Reset asserted during WAIT_R -> all outputs are 0; no up_rdone after release; the next transaction completes normally.
